// File: rtl/sync_pkg.sv
// Shared constants and types for the video timing sequencer:
// sync PROM bit positions, line-phase states and default horizontal timing.
package sync_pkg;

    localparam int SP_VBLANK = 3;
    localparam int SP_VRESET = 2;
    localparam int SP_VINT   = 1;
    localparam int SP_VSYNC  = 0;

    localparam int DEF_H_TOTAL      = 384;
    localparam int DEF_HBLANK_START = 256;
    localparam int DEF_HSYNC_START  = 288;
    localparam int DEF_HSYNC_END    = 320;
    localparam int DEF_SAMPLE_H     = 260;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } line_phase_e;

endpackage

// File: rtl/h_timing.sv
// Horizontal counter and line-phase FSM; produces registered hblank/hsync
// and a combinational end-of-line strobe qualified by the pixel enable.
module h_timing
    import sync_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int HBLANK_START = DEF_HBLANK_START,
    parameter int HSYNC_START  = DEF_HSYNC_START,
    parameter int HSYNC_END    = DEF_HSYNC_END
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_ce_pix,
    output logic [8:0] o_hcount,
    output logic       o_hblank,
    output logic       o_hsync,
    output logic       o_eol
);

    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] HB_FROM = 9'(HBLANK_START);
    localparam logic [8:0] HS_FROM = 9'(HSYNC_START);
    localparam logic [8:0] HS_TO   = 9'(HSYNC_END);

    line_phase_e r_state;
    line_phase_e w_next_state;
    logic [8:0]  r_hcount;
    logic [8:0]  w_hcount_nxt;
    logic        r_hblank;
    logic        r_hsync;
    logic        w_eol;

    assign w_eol = i_ce_pix && (r_hcount == H_LAST);

    // Phase transitions key off the next count so hblank/hsync change in the
    // same clock where hcount reaches the boundary value.
    always_comb begin
        w_next_state = r_state;
        w_hcount_nxt = r_hcount;
        if (i_ce_pix) begin
            w_hcount_nxt = w_eol ? 9'd0 : r_hcount + 9'd1;
            case (r_state)
                ACTIVE:  if (w_hcount_nxt == HB_FROM) w_next_state = FRONT;
                FRONT:   if (w_hcount_nxt == HS_FROM) w_next_state = SYNC;
                SYNC:    if (w_hcount_nxt == HS_TO)   w_next_state = BACK;
                BACK:    if (w_hcount_nxt == 9'd0)    w_next_state = ACTIVE;
                default: w_next_state = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ACTIVE;
            r_hcount <= 9'd0;
            r_hblank <= 1'b0;
            r_hsync  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_hcount <= w_hcount_nxt;
            r_hblank <= (w_next_state != ACTIVE);
            r_hsync  <= (w_next_state == SYNC);
        end
    end

    assign o_hcount = r_hcount;
    assign o_hblank = r_hblank;
    assign o_hsync  = r_hsync;
    assign o_eol    = w_eol;

endmodule

// File: rtl/sync_sequencer.sv
// Video timing sequencer: horizontal timing from parameters, vertical timing
// stepped through an external synchronous sync PROM addressed by vcount.
module sync_sequencer
    import sync_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int HBLANK_START = DEF_HBLANK_START,
    parameter int HSYNC_START  = DEF_HSYNC_START,
    parameter int HSYNC_END    = DEF_HSYNC_END,
    parameter int SAMPLE_H     = DEF_SAMPLE_H
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_pix,
    output logic [7:0] prom_addr,
    input  logic [3:0] prom_q,
    output logic [8:0] hcount,
    output logic [7:0] vcount,
    output logic       hblank,
    output logic       hsync,
    output logic       vblank,
    output logic       vsync,
    output logic       vint,
    output logic       line_start
);

    localparam logic [8:0] SAMPLE_AT = 9'(SAMPLE_H);

    logic [8:0] w_hcount;
    logic       w_hblank;
    logic       w_hsync;
    logic       w_eol;
    logic [7:0] w_vcount_nxt;

    logic [7:0] r_vcount;
    logic [7:0] r_prom_addr;
    logic [3:0] r_line_flags;
    logic       r_vblank;
    logic       r_vsync;
    logic       r_vint_level;
    logic       r_vint_prev;
    logic       r_vint;
    logic       r_line_start;

    h_timing #(
        .H_TOTAL      (H_TOTAL),
        .HBLANK_START (HBLANK_START),
        .HSYNC_START  (HSYNC_START),
        .HSYNC_END    (HSYNC_END)
    ) u_h_timing (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_ce_pix (ce_pix),
        .o_hcount (w_hcount),
        .o_hblank (w_hblank),
        .o_hsync  (w_hsync),
        .o_eol    (w_eol)
    );

    // vreset on line 255 yields 0, which is also the natural wrap.
    assign w_vcount_nxt = r_line_flags[SP_VRESET] ? 8'd0 : r_vcount + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vcount     <= 8'd0;
            r_prom_addr  <= 8'd0;
            r_line_flags <= 4'd0;
            r_vblank     <= 1'b0;
            r_vsync      <= 1'b0;
            r_vint_level <= 1'b0;
            r_vint_prev  <= 1'b0;
            r_vint       <= 1'b0;
            r_line_start <= 1'b0;
        end else begin
            r_line_start <= w_eol;
            // Edge detect runs on pixel enables so the pulse never lands
            // in a clock without ce_pix.
            r_vint <= ce_pix && r_vint_level && !r_vint_prev;
            if (ce_pix)
                r_vint_prev <= r_vint_level;
            if (ce_pix && (w_hcount == SAMPLE_AT))
                r_line_flags <= prom_q;
            if (w_eol) begin
                r_vcount     <= w_vcount_nxt;
                r_prom_addr  <= w_vcount_nxt;
                r_vblank     <= r_line_flags[SP_VBLANK];
                r_vsync      <= r_line_flags[SP_VSYNC];
                r_vint_level <= r_line_flags[SP_VINT];
            end
        end
    end

    assign prom_addr  = r_prom_addr;
    assign hcount     = w_hcount;
    assign vcount     = r_vcount;
    assign hblank     = w_hblank;
    assign hsync      = w_hsync;
    assign vblank     = r_vblank;
    assign vsync      = r_vsync;
    assign vint       = r_vint;
    assign line_start = r_line_start;

endmodule

// File: tb/tb_sync_sequencer.sv
// Directed bench for sync_sequencer: bench-side sync PROM, per-clock rule
// checks aggregated per phase, frame length, vint placement, reset and 1/4 rate.
module tb_sync_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic [7:0] prom_addr;
    logic [3:0] prom_q = 4'd0;
    logic [8:0] hcount;
    logic [7:0] vcount;
    logic       hblank, hsync, vblank, vsync, vint, line_start;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] rom [256];

    sync_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .prom_addr  (prom_addr),
        .prom_q     (prom_q),
        .hcount     (hcount),
        .vcount     (vcount),
        .hblank     (hblank),
        .hsync      (hsync),
        .vblank     (vblank),
        .vsync      (vsync),
        .vint       (vint),
        .line_start (line_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) prom_q <= rom[prom_addr];

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // expectation state, advanced by hand rules per clock
    int exp_h = 0, exp_v = 0, prev_v = 0;
    bit has_prev = 0;
    int err_h = 0, err_v = 0, err_pa = 0, err_hb = 0, err_hs = 0;
    int err_ls = 0, err_vb = 0, err_vs = 0, err_vi = 0;
    int vint_cnt = 0, vint_line = -1, vint_h = -1;
    int lines_since = 0, ls_cnt = 0;
    bit seen0 = 0;

    task automatic cyc(input logic ce_v);
        bit wrapped;
        bit e_vb, e_vs, e_vi, e_ls;
        wrapped = 0;
        ce_pix = ce_v;
        @(posedge clock);
        if (reset) begin
            exp_h = 0; exp_v = 0; has_prev = 0;
        end else if (ce_v) begin
            if (exp_h == 383) begin
                exp_h = 0; wrapped = 1;
                prev_v = exp_v; has_prev = 1;
                exp_v = (exp_v == 8'h85) ? 0 : exp_v + 1;
            end else begin
                exp_h++;
            end
        end
        @(negedge clock);
        e_ls = wrapped;
        e_vb = has_prev && prev_v >= 8'h7f && prev_v <= 8'h85;
        e_vs = has_prev && prev_v >= 8'h80 && prev_v <= 8'h82;
        e_vi = !reset && ce_v && exp_v == 8'h81 && exp_h == 1;
        if (int'(hcount) != exp_h) err_h++;
        if (int'(vcount) != exp_v) err_v++;
        if (int'(prom_addr) != exp_v) err_pa++;
        if (hblank != (exp_h >= 256)) err_hb++;
        if (hsync != (exp_h >= 288 && exp_h < 320)) err_hs++;
        if (line_start != e_ls) err_ls++;
        if (vblank != e_vb) err_vb++;
        if (vsync != e_vs) err_vs++;
        if (vint != e_vi) err_vi++;
        if (vint) begin
            vint_cnt++; vint_line = int'(vcount); vint_h = int'(hcount);
        end
        if (line_start) begin
            ls_cnt++;
            lines_since++;
            if (vcount == 8'd0) begin
                if (seen0) chk("frame_len", lines_since, 134);
                lines_since = 0;
                seen0 = 1;
            end
        end
    endtask

    task automatic chk_errs(input string ph);
        chk({ph, "_hcount"}, err_h, 0);
        chk({ph, "_vcount"}, err_v, 0);
        chk({ph, "_prom_addr"}, err_pa, 0);
        chk({ph, "_hblank"}, err_hb, 0);
        chk({ph, "_hsync"}, err_hs, 0);
        chk({ph, "_line_start"}, err_ls, 0);
        chk({ph, "_vblank"}, err_vb, 0);
        chk({ph, "_vsync"}, err_vs, 0);
        chk({ph, "_vint"}, err_vi, 0);
        err_h = 0; err_v = 0; err_pa = 0; err_hb = 0; err_hs = 0;
        err_ls = 0; err_vb = 0; err_vs = 0; err_vi = 0;
    endtask

    task automatic chk_all_zero(input string ph);
        chk({ph, "_hcount0"}, int'(hcount), 0);
        chk({ph, "_vcount0"}, int'(vcount), 0);
        chk({ph, "_prom_addr0"}, int'(prom_addr), 0);
        chk({ph, "_hblank0"}, int'(hblank), 0);
        chk({ph, "_hsync0"}, int'(hsync), 0);
        chk({ph, "_vblank0"}, int'(vblank), 0);
        chk({ph, "_vsync0"}, int'(vsync), 0);
        chk({ph, "_vint0"}, int'(vint), 0);
        chk({ph, "_line_start0"}, int'(line_start), 0);
    endtask

    initial begin
        bit reached;
        // PROM: vblank 7f-85, vreset 85, vint 80-84, vsync 80-82
        for (int a = 0; a < 256; a++) begin
            rom[a] = 4'd0;
            if (a >= 8'h7f && a <= 8'h85) rom[a][3] = 1'b1;
            if (a == 8'h85)               rom[a][2] = 1'b1;
            if (a >= 8'h80 && a <= 8'h84) rom[a][1] = 1'b1;
            if (a >= 8'h80 && a <= 8'h82) rom[a][0] = 1'b1;
        end

        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1);
        chk_all_zero("rst");
        reset = 1'b0;
        cyc(1'b1);
        chk("h_after_release", int'(hcount), 1);

        // full rate: one whole frame, then on to line 0x40 hcount 200
        reached = 0;
        for (int i = 0; i < 80000; i++) begin
            cyc(1'b1);
            if (lines_since == 8'h40 && seen0 && ls_cnt > 134 &&
                vcount == 8'h40 && hcount == 9'd200) begin
                reached = 1;
                break;
            end
        end
        chk("reach_mid_frame", int'(reached), 1);
        chk_errs("full");
        chk("vint_pulses", vint_cnt, 1);
        chk("vint_line", vint_line, 8'h81);
        chk("vint_hcount", vint_h, 1);

        reset = 1'b1;
        cyc(1'b1);
        chk_all_zero("midrst");
        reset = 1'b0;
        seen0 = 1; lines_since = 0; ls_cnt = 0; vint_cnt = 0;

        // quarter rate: 800 pixel enables = 2 lines + 32 pixels
        for (int i = 0; i < 3200; i++) cyc(i % 4 == 0);
        chk_errs("quarter");
        chk("q_hcount_end", int'(hcount), 32);
        chk("q_vcount_end", int'(vcount), 2);
        chk("q_line_starts", ls_cnt, 2);
        chk("q_vint_pulses", vint_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
